bcd_modn_counter: RTL and testbench

- Parametrised multi-digit BCD counter with programmable modulus, up/down direction, synchronous clear and parallel load.
- Next generation of the fixed two-digit mod-60 BCD counter.
- Chains into clock and timer datapaths (seconds, minutes, hours, frame counters) through ripple-enable outputs.
- One instance per time field; the carry/borrow of one instance drives CE of the next.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_modn_counter_digit.sv | 52 +++++
 rtl/bcd_modn_counter.sv | 75 +++++++
 tb/tb_bcd_modn_counter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and elaboration-time helpers for the modulus-N BCD counter.
// Vectors are fixed at four digits; callers slice down to their own width.
package bcd_pkg;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam int         MAX_DIGITS = 4;

    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value, input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 10);
            end
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] vec, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && vec[4*i +: 4] > DIGIT_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_modn_counter_digit.sv
// One BCD digit of the counter: clear > load > forced wrap > step; value registered, one cycle.
// No backpressure; the top decides when this digit steps or wraps.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       clr_i,
    input  logic       ld_i,
    input  logic [3:0] ld_nib_i,
    input  logic       wrap_i,
    input  logic [3:0] wrap_nib_i,
    output logic [3:0] dig_o,
    output logic       at9_o,
    output logic       at0_o
);

    logic [3:0] dig_q;
    logic [3:0] dig_d;

    assign dig_o = dig_q;
    assign at9_o = (dig_q == DIGIT_MAX);
    assign at0_o = (dig_q == 4'd0);

    always_comb begin
        dig_d = dig_q;
        if (clr_i) begin
            dig_d = 4'd0;
        end else if (ld_i) begin
            dig_d = ld_nib_i;
        end else if (wrap_i) begin
            dig_d = wrap_nib_i;
        end else if (step_i) begin
            if (dir_i) begin
                dig_d = at0_o ? DIGIT_MAX : dig_q - 4'd1;
            end else begin
                dig_d = at9_o ? 4'd0 : dig_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dig_q <= 4'd0;
        end else begin
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/bcd_modn_counter.sv
// Multi-digit BCD up/down counter modulo MODULUS with clear, checked load and ripple carry/borrow.
// CNT/ERR registered one cycle; UP/DN combinational so the next stage's CE sees them before the edge.
module bcd_modn_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE,
    input  logic                DIR,
    input  logic                CLR,
    input  logic                LD,
    input  logic [4*DIGITS-1:0] LD_VAL,
    output logic [4*DIGITS-1:0] CNT,
    output logic                UP,
    output logic                DN,
    output logic                ERR
);

    localparam int                       W         = 4 * DIGITS;
    localparam logic [4*MAX_DIGITS-1:0]  TERM_FULL = to_bcd(MODULUS - 1, DIGITS);
    localparam logic [W-1:0]             TERM      = TERM_FULL[W-1:0];

    logic [DIGITS:0]   chain;
    logic [DIGITS-1:0] at9;
    logic [DIGITS-1:0] at0;
    logic              go;
    logic              at_term;
    logic              wrap;
    logic              ld_ok;
    logic              err_q;
    logic              err_d;

    // Both operands are legal BCD here, so packed compare equals decimal compare.
    assign ld_ok   = bcd_valid((4*MAX_DIGITS)'(LD_VAL), DIGITS) && (LD_VAL <= TERM);
    assign go      = CE & ~CLR & ~LD;
    assign at_term = (CNT == TERM);
    assign chain[0] = 1'b1;
    // chain[DIGITS] means every digit is at 0 (down) or 9 (up): the down wrap point.
    assign wrap    = go & (DIR ? chain[DIGITS] : at_term);
    assign UP      = go & ~DIR & at_term;
    assign DN      = go &  DIR & chain[DIGITS];
    assign err_d   = ~CLR & LD & ~ld_ok;
    assign ERR     = err_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign chain[i+1] = chain[i] & (DIR ? at0[i] : at9[i]);

        bcd_digit u_digit (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .step_i     (go & chain[i]),
            .dir_i      (DIR),
            .clr_i      (CLR),
            .ld_i       (LD & ld_ok),
            .ld_nib_i   (LD_VAL[4*i +: 4]),
            .wrap_i     (wrap),
            .wrap_nib_i (DIR ? TERM[4*i +: 4] : 4'd0),
            .dig_o      (CNT[4*i +: 4]),
            .at9_o      (at9[i]),
            .at0_o      (at0[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Drives a mod-60 and a mod-24 two-digit counter with identical stimulus and
// compares both against a decimal-integer reference model every cycle.
module tb_bcd_modn_counter;

    logic       CLK = 1'b0;
    logic       RST_N, CE, DIR, CLR, LD;
    logic [7:0] LD_VAL;
    logic [7:0] cnt60, cnt24;
    logic       up60, dn60, err60, up24, dn24, err24;
    logic [21:0] obs;

    int vectors = 0;
    int miscompares = 0;
    int m_cnt [2];
    bit m_err [2];

    always #5 CLK = ~CLK;

    bcd_modn_counter #(.DIGITS(2), .MODULUS(60)) dut60 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .DIR(DIR), .CLR(CLR), .LD(LD),
        .LD_VAL(LD_VAL), .CNT(cnt60), .UP(up60), .DN(dn60), .ERR(err60)
    );

    bcd_modn_counter #(.DIGITS(2), .MODULUS(24)) dut24 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .DIR(DIR), .CLR(CLR), .LD(LD),
        .LD_VAL(LD_VAL), .CNT(cnt24), .UP(up24), .DN(dn24), .ERR(err24)
    );

    assign obs = {cnt60, up60, dn60, err60, cnt24, up24, dn24, err24};

    function automatic int mod_of(input int k);
        return (k == 0) ? 60 : 24;
    endfunction

    function automatic logic [7:0] dec2bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [10:0] e [2];
        for (int k = 0; k < 2; k++) begin
            bit u, d;
            u = CE && !DIR && !CLR && !LD && (m_cnt[k] == mod_of(k) - 1);
            d = CE &&  DIR && !CLR && !LD && (m_cnt[k] == 0);
            e[k] = {dec2bcd(m_cnt[k]), u, d, m_err[k]};
        end
        return {e[0], e[1]};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int m, hi, lo, v;
            m = mod_of(k);
            if (CLR) begin
                m_cnt[k] = 0;
                m_err[k] = 1'b0;
            end else if (LD) begin
                hi = int'(LD_VAL[7:4]);
                lo = int'(LD_VAL[3:0]);
                v  = hi * 10 + lo;
                if (hi <= 9 && lo <= 9 && v < m) begin
                    m_cnt[k] = v;
                    m_err[k] = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
            end else begin
                m_err[k] = 1'b0;
                if (CE) m_cnt[k] = DIR ? (m_cnt[k] + m - 1) % m : (m_cnt[k] + 1) % m;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) model_edge();
        @(negedge CLK);
    endtask

    task automatic apply(input bit ce, input bit dir, input bit clr, input bit ld, input logic [7:0] v);
        CE = ce; DIR = dir; CLR = clr; LD = ld; LD_VAL = v;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL reset c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            tick();
        end
        RST_N = 1'b1;
    endtask

    task automatic test_up_count();
        int ups = 0;
        for (int c = 0; c < 61; c++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL up_count c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            if (up60) ups++;
            tick();
        end
        vectors++;
        if (ups !== 1) begin
            $display("FAIL up_pulse_count got=%0d want=1", ups);
            miscompares++;
        end
    endtask

    task automatic test_down_count();
        int dns = 0;
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        for (int c = 0; c < 25; c++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL down_count c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            if (dn60) dns++;
            tick();
        end
        vectors++;
        if (dns !== 1) begin
            $display("FAIL dn_pulse_count got=%0d want=1", dns);
            miscompares++;
        end
    endtask

    task automatic test_mod24();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h19);
        tick();
        for (int c = 0; c < 7; c++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL mod24 c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [7:0] vals [5];
        bit         lds  [5];
        vals = '{8'h45, 8'h3A, 8'h00, 8'h60, 8'h00};
        lds  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            apply(1'b0, 1'b0, 1'b0, lds[c], vals[c]);
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL load c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            tick();
        end
        #1;
        vectors++;
        if (obs !== exp_vec()) begin
            $display("FAIL load_final got=%h want=%h", obs, exp_vec());
            miscompares++;
        end
    endtask

    task automatic test_priority();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h59);
        tick();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
                1:       apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h12);
                default: apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            endcase
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL priority c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h37);
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        RST_N = 1'b0;
        m_cnt = '{0, 0};
        m_err = '{1'b0, 1'b0};
        #1;
        vectors++;
        if (obs !== exp_vec()) begin
            $display("FAIL async_reset got=%h want=%h", obs, exp_vec());
            miscompares++;
        end
        #1;
        RST_N = 1'b1;
        tick();
        #1;
        vectors++;
        if (obs !== exp_vec()) begin
            $display("FAIL async_resume got=%h want=%h", obs, exp_vec());
            miscompares++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 1) == 1) ? dec2bcd($urandom_range(0, 99)) : 8'($urandom);
            apply($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31) == 0,
                  $urandom_range(0, 11) == 0, v);
            #1;
            vectors++;
            if (obs !== exp_vec()) begin
                $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_vec());
                miscompares++;
            end
            tick();
        end
    endtask

    initial begin
        RST_N = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        m_cnt = '{0, 0};
        m_err = '{1'b0, 1'b0};
        @(negedge CLK);
        test_reset();
        test_up_count();
        test_down_count();
        test_mod24();
        test_load();
        test_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
